// File: rtl/x_bufgmux_n.sv
// Glitch-free N-input clock/waveform mux: waits for the old source to
// go idle, parks for a dead time, then waits for the new source to be idle.
module x_bufgmux_n #(
    parameter int N           = 4,
    parameter int SELW        = 2,
    parameter int INIT_OUT    = 0,
    parameter int PRESELECT   = 0,
    parameter int DEAD_CYCLES = 2,
    parameter int TIMEOUT     = 0
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [N-1:0]    I,
    input  logic [N-1:0]    CE,
    input  logic [N-1:0]    IGNORE,
    input  logic [SELW-1:0] S,
    output logic            O,
    output logic [N-1:0]    ACTIVE,
    output logic            BUSY,
    output logic            TIMEOUT_ERR
);

    typedef enum logic [2:0] {
        LOCKED,
        PARKED,
        WAIT_OLD,
        DEAD,
        WAIT_NEW
    } state_t;

    localparam logic            INIT    = (INIT_OUT != 0);
    localparam logic            PARK    = (PRESELECT < 0);
    localparam logic [SELW-1:0] PRE_IDX = PARK ? '0 : SELW'(PRESELECT);
    localparam logic [N-1:0]    PRE_ACT = PARK ? '0 : (N'(1) << PRE_IDX);
    localparam logic [SELW:0]   NUM     = (SELW+1)'(N);
    localparam logic [3:0]      DLAST   =
        (DEAD_CYCLES == 0) ? 4'd0 : 4'(DEAD_CYCLES - 1);
    localparam logic [15:0]     TLAST   =
        (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);
    localparam logic            TEN     = (TIMEOUT > 0);

    state_t          state;
    logic [SELW-1:0] cur;
    logic [SELW-1:0] nxt;
    logic            nxt_vld;
    logic [15:0]     wcnt;
    logic [3:0]      dcnt;

    logic            tgt_vld;
    logic            cur_idle;
    logic            nxt_idle;
    logic            expire;

    function automatic logic [N-1:0] onehot(input logic [SELW-1:0] k);
        logic [N-1:0] r;
        r    = '0;
        r[k] = 1'b1;
        return r;
    endfunction

    always_comb begin
        tgt_vld  = ({1'b0, S} < NUM) && CE[S];
        cur_idle = (I[cur] == INIT) || IGNORE[cur];
        nxt_idle = (I[nxt] == INIT) || IGNORE[nxt];
        expire   = TEN && (wcnt == TLAST);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= PARK ? PARKED : LOCKED;
            cur         <= PRE_IDX;
            nxt         <= '0;
            nxt_vld     <= 1'b0;
            wcnt        <= '0;
            dcnt        <= '0;
            O           <= INIT;
            ACTIVE      <= PRE_ACT;
            BUSY        <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
        end else begin
            unique case (state)
                LOCKED: begin
                    O <= I[cur];
                    if (!tgt_vld || S != cur) begin
                        nxt     <= S;
                        nxt_vld <= tgt_vld;
                        wcnt    <= '0;
                        BUSY    <= 1'b1;
                        state   <= WAIT_OLD;
                    end
                end
                PARKED: begin
                    O <= INIT;
                    if (tgt_vld) begin
                        nxt     <= S;
                        nxt_vld <= 1'b1;
                        dcnt    <= '0;
                        BUSY    <= 1'b1;
                        state   <= DEAD;
                    end
                end
                WAIT_OLD: begin
                    if (cur_idle || expire) begin
                        O      <= INIT;
                        ACTIVE <= '0;
                        dcnt   <= '0;
                        state  <= DEAD;
                        if (!cur_idle)
                            TIMEOUT_ERR <= 1'b1;
                    end else begin
                        O    <= I[cur];
                        wcnt <= wcnt + 16'd1;
                    end
                end
                DEAD: begin
                    O <= INIT;
                    if (dcnt == DLAST) begin
                        dcnt  <= '0;
                        wcnt  <= '0;
                        BUSY  <= nxt_vld;
                        state <= nxt_vld ? WAIT_NEW : PARKED;
                    end else begin
                        dcnt <= dcnt + 4'd1;
                    end
                end
                WAIT_NEW: begin
                    O <= INIT;
                    if (nxt_idle || expire) begin
                        cur     <= nxt;
                        ACTIVE  <= onehot(nxt);
                        nxt_vld <= 1'b0;
                        BUSY    <= 1'b0;
                        state   <= LOCKED;
                        if (!nxt_idle)
                            TIMEOUT_ERR <= 1'b1;
                    end else begin
                        wcnt <= wcnt + 16'd1;
                    end
                end
                default: begin
                    O       <= INIT;
                    ACTIVE  <= '0;
                    nxt_vld <= 1'b0;
                    BUSY    <= 1'b0;
                    state   <= PARKED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_x_bufgmux_n.sv
// Directed vector bench for x_bufgmux_n: a 4-input instance locked to 0
// with TIMEOUT=5, and a 6-input instance parked after reset.
module tb_x_bufgmux_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, o_a, busy_a, err_a;
    logic [3:0] i_a, ce_a, ign_a, act_a;
    logic [1:0] s_a;

    logic       rst_b, o_b, busy_b, err_b;
    logic [5:0] i_b, ce_b, ign_b, act_b;
    logic [2:0] s_b;

    x_bufgmux_n #(
        .N(4), .SELW(2), .INIT_OUT(0), .PRESELECT(0),
        .DEAD_CYCLES(2), .TIMEOUT(5)
    ) dut_a (
        .CLK(clk), .RST(rst_a), .I(i_a), .CE(ce_a), .IGNORE(ign_a),
        .S(s_a), .O(o_a), .ACTIVE(act_a), .BUSY(busy_a),
        .TIMEOUT_ERR(err_a)
    );

    x_bufgmux_n #(
        .N(6), .SELW(3), .INIT_OUT(0), .PRESELECT(-1),
        .DEAD_CYCLES(2), .TIMEOUT(0)
    ) dut_b (
        .CLK(clk), .RST(rst_b), .I(i_b), .CE(ce_b), .IGNORE(ign_b),
        .S(s_b), .O(o_b), .ACTIVE(act_b), .BUSY(busy_b),
        .TIMEOUT_ERR(err_b)
    );

    typedef struct {
        logic       rst;
        logic [5:0] i;
        logic [5:0] ce;
        logic [5:0] ign;
        logic [2:0] s;
        logic       o;
        logic [5:0] act;
        logic       busy;
        logic       err;
    } vec_t;

    int nvec = 0;
    int nbad = 0;

    function automatic vec_t mk(
        logic rst, logic [5:0] i, logic [5:0] ce, logic [5:0] ign,
        logic [2:0] s, logic o, logic [5:0] act, logic busy, logic err);
        vec_t v;
        v.rst = rst; v.i = i; v.ce = ce; v.ign = ign; v.s = s;
        v.o = o; v.act = act; v.busy = busy; v.err = err;
        return v;
    endfunction

    task automatic chk(string nm, int k, logic [5:0] got, logic [5:0] exp);
        if (got !== exp) begin
            $display("FAIL %s[%0d] got %h expected %h", nm, k, got, exp);
            nbad++;
        end
    endtask

    task automatic run(vec_t v, int k, bit b);
        if (!b) begin
            rst_a = v.rst; i_a = v.i[3:0]; ce_a = v.ce[3:0];
            ign_a = v.ign[3:0]; s_a = v.s[1:0];
        end else begin
            rst_b = v.rst; i_b = v.i; ce_b = v.ce;
            ign_b = v.ign; s_b = v.s;
        end
        @(posedge clk);
        #1;
        nvec++;
        if (!b) begin
            chk("a.O", k, {5'd0, o_a}, {5'd0, v.o});
            chk("a.ACTIVE", k, {2'd0, act_a}, v.act);
            chk("a.BUSY", k, {5'd0, busy_a}, {5'd0, v.busy});
            chk("a.ERR", k, {5'd0, err_a}, {5'd0, v.err});
        end else begin
            chk("b.O", k, {5'd0, o_b}, {5'd0, v.o});
            chk("b.ACTIVE", k, act_b, v.act);
            chk("b.BUSY", k, {5'd0, busy_b}, {5'd0, v.busy});
            chk("b.ERR", k, {5'd0, err_b}, {5'd0, v.err});
        end
    endtask

    vec_t ta[$];
    vec_t tb[$];
    int   n;

    initial begin
        rst_a = 1'b1; i_a = '0; ce_a = '1; ign_a = '0; s_a = '0;
        rst_b = 1'b1; i_b = '0; ce_b = '1; ign_b = '0; s_b = '0;

        // rst, I, CE, IGNORE, S  |  O, ACTIVE, BUSY, ERR
        ta.push_back(mk(1, 'h0, 'hF, 0, 0, 0, 'h1, 0, 0));
        ta.push_back(mk(0, 'h1, 'hF, 0, 0, 1, 'h1, 0, 0));
        ta.push_back(mk(0, 'h1, 'hF, 0, 0, 1, 'h1, 0, 0));
        ta.push_back(mk(0, 'h1, 'hF, 0, 0, 1, 'h1, 0, 0));
        ta.push_back(mk(0, 'h0, 'hF, 0, 0, 0, 'h1, 0, 0));
        ta.push_back(mk(0, 'h0, 'hF, 0, 0, 0, 'h1, 0, 0));
        ta.push_back(mk(0, 'h0, 'hF, 0, 0, 0, 'h1, 0, 0));
        ta.push_back(mk(0, 'h1, 'hF, 0, 0, 1, 'h1, 0, 0));
        ta.push_back(mk(0, 'h1, 'hF, 0, 2, 1, 'h1, 1, 0));
        ta.push_back(mk(0, 'h1, 'hF, 0, 2, 1, 'h1, 1, 0));
        ta.push_back(mk(0, 'h4, 'hF, 0, 2, 0, 'h0, 1, 0));
        ta.push_back(mk(0, 'h4, 'hF, 0, 2, 0, 'h0, 1, 0));
        ta.push_back(mk(0, 'h4, 'hF, 0, 2, 0, 'h0, 1, 0));
        ta.push_back(mk(0, 'h4, 'hF, 0, 2, 0, 'h0, 1, 0));
        ta.push_back(mk(0, 'h0, 'hF, 0, 2, 0, 'h4, 0, 0));
        ta.push_back(mk(0, 'h4, 'hF, 0, 2, 1, 'h4, 0, 0));
        ta.push_back(mk(0, 'h0, 'hF, 0, 2, 0, 'h4, 0, 0));
        ta.push_back(mk(1, 'h0, 'hF, 0, 2, 0, 'h1, 0, 0));
        ta.push_back(mk(0, 'h1, 'hF, 1, 0, 1, 'h1, 0, 0));
        ta.push_back(mk(0, 'h1, 'hF, 1, 1, 1, 'h1, 1, 0));
        ta.push_back(mk(0, 'h1, 'hF, 1, 1, 0, 'h0, 1, 0));
        ta.push_back(mk(0, 'h1, 'hF, 1, 1, 0, 'h0, 1, 0));
        ta.push_back(mk(0, 'h1, 'hF, 1, 1, 0, 'h0, 1, 0));
        ta.push_back(mk(0, 'h1, 'hF, 1, 1, 0, 'h2, 0, 0));
        ta.push_back(mk(0, 'h3, 'hF, 1, 1, 1, 'h2, 0, 0));
        for (int k = 0; k < 5; k++)
            ta.push_back(mk(0, 'h2, 'hF, 0, 3, 1, 'h2, 1, 0));
        ta.push_back(mk(0, 'h2, 'hF, 0, 3, 0, 'h0, 1, 1));
        ta.push_back(mk(0, 'h2, 'hF, 0, 3, 0, 'h0, 1, 1));
        ta.push_back(mk(0, 'h2, 'hF, 0, 3, 0, 'h0, 1, 1));
        ta.push_back(mk(0, 'h2, 'hF, 0, 3, 0, 'h8, 0, 1));
        ta.push_back(mk(0, 'hA, 'hF, 0, 3, 1, 'h8, 0, 1));
        ta.push_back(mk(1, 'hA, 'hF, 0, 3, 0, 'h1, 0, 0));

        tb.push_back(mk(1, 'h00, 'h3F, 0, 0, 0, 'h00, 0, 0));
        tb.push_back(mk(0, 'h02, 'h3F, 0, 1, 0, 'h00, 1, 0));
        tb.push_back(mk(0, 'h02, 'h3F, 0, 1, 0, 'h00, 1, 0));
        tb.push_back(mk(0, 'h02, 'h3F, 0, 1, 0, 'h00, 1, 0));
        tb.push_back(mk(0, 'h02, 'h3F, 0, 1, 0, 'h00, 1, 0));
        tb.push_back(mk(0, 'h00, 'h3F, 0, 1, 0, 'h02, 0, 0));
        tb.push_back(mk(0, 'h02, 'h3F, 0, 1, 1, 'h02, 0, 0));
        tb.push_back(mk(0, 'h00, 'h1F, 0, 5, 0, 'h02, 1, 0));
        tb.push_back(mk(0, 'h00, 'h1F, 0, 5, 0, 'h00, 1, 0));
        tb.push_back(mk(0, 'h00, 'h1F, 0, 2, 0, 'h00, 1, 0));
        tb.push_back(mk(0, 'h00, 'h1F, 0, 2, 0, 'h00, 0, 0));
        tb.push_back(mk(0, 'h00, 'h1F, 0, 2, 0, 'h00, 1, 0));
        tb.push_back(mk(0, 'h00, 'h1F, 0, 2, 0, 'h00, 1, 0));
        tb.push_back(mk(1, 'h00, 'h1F, 0, 2, 0, 'h00, 0, 0));
        tb.push_back(mk(0, 'h00, 'h1F, 0, 7, 0, 'h00, 0, 0));
        tb.push_back(mk(0, 'h08, 'h08, 0, 3, 0, 'h00, 1, 0));
        tb.push_back(mk(0, 'h08, 'h08, 0, 3, 0, 'h00, 1, 0));
        tb.push_back(mk(0, 'h08, 'h00, 0, 3, 0, 'h00, 1, 0));
        tb.push_back(mk(0, 'h08, 'h00, 0, 3, 0, 'h00, 1, 0));
        tb.push_back(mk(0, 'h00, 'h00, 0, 3, 0, 'h08, 0, 0));
        tb.push_back(mk(0, 'h08, 'h00, 0, 3, 1, 'h08, 1, 0));
        tb.push_back(mk(0, 'h08, 'h00, 0, 3, 1, 'h08, 1, 0));
        tb.push_back(mk(0, 'h00, 'h00, 0, 3, 0, 'h00, 1, 0));

        foreach (ta[k]) run(ta[k], k, 1'b0);
        foreach (tb[k]) run(tb[k], k, 1'b1);

        // Idle-to-idle handover 0 -> 1 must lock after exactly five edges.
        rst_a = 1'b0; i_a = '0; ce_a = '1; ign_a = '0; s_a = 2'd1;
        n = 0;
        while (n < 20 && act_a !== 4'b0010) begin
            @(posedge clk);
            #1;
            n++;
        end
        nvec++;
        chk("seq.lock_edges", 0, 6'(n), 6'd5);
        chk("seq.busy", 0, {5'd0, busy_a}, 6'd0);
        i_a = 4'b0010;
        @(posedge clk);
        #1;
        nvec++;
        chk("seq.follow", 0, {5'd0, o_a}, 6'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
